// File: rtl/bp_be_trap_sequencer.sv
// Trap sequencer: resolves one trap cause per accepted offer, then flushes, writes mcause/mepc/mtval and redirects.
// Optional macro BP_TRAP_VECTORED_EN enables vectored interrupt targets when mtvec_i[1:0]==2'b01.
module bp_be_trap_sequencer #(
    parameter int unsigned vaddr_width_p = 39
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,
    input  logic                     exc_v_i,
    input  logic [15:0]              exc_i,
    input  logic [vaddr_width_p-1:0] exc_pc_i,
    input  logic [63:0]              exc_tval_i,
    output logic                     exc_ready_o,
    input  logic [2:0]               irq_i,
    input  logic                     irq_en_i,
    input  logic [63:0]              mtvec_i,
    output logic                     csr_w_v_o,
    output logic [11:0]              csr_w_addr_o,
    output logic [63:0]              csr_w_data_o,
    input  logic                     csr_w_ready_i,
    output logic                     flush_o,
    output logic                     redirect_v_o,
    output logic [63:0]              redirect_pc_o,
    output logic                     busy_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_W_CAUSE,
        S_W_EPC,
        S_W_TVAL,
        S_REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] cause_q, cause_d;
    logic [63:0] epc_q, epc_d;
    logic [63:0] tval_q, tval_d;
    logic [63:0] target_q, target_d;

    logic [2:0]  irq_act;
    logic        is_irq;
    logic        is_exc;
    logic [3:0]  code;
    logic [63:0] base;
    logic [63:0] target;

    // Bits 14 and 10 are reserved and masked out of the exception test.
    always_comb begin
        irq_act = irq_i & {3{irq_en_i}};
        is_irq  = |irq_act;
        is_exc  = |(exc_i & 16'hBBFF);
        code    = '0;
        if (irq_act[2])      code = 4'd11;
        else if (irq_act[0]) code = 4'd3;
        else if (irq_act[1]) code = 4'd7;
        else if (exc_i[12])  code = 4'd12;
        else if (exc_i[1])   code = 4'd1;
        else if (exc_i[2])   code = 4'd2;
        else if (exc_i[0])   code = 4'd0;
        else if (exc_i[3])   code = 4'd3;
        else if (exc_i[11])  code = 4'd11;
        else if (exc_i[9])   code = 4'd9;
        else if (exc_i[8])   code = 4'd8;
        else if (exc_i[6])   code = 4'd6;
        else if (exc_i[4])   code = 4'd4;
        else if (exc_i[15])  code = 4'd15;
        else if (exc_i[13])  code = 4'd13;
        else if (exc_i[7])   code = 4'd7;
        else if (exc_i[5])   code = 4'd5;
    end

    always_comb begin
        base   = {mtvec_i[63:2], 2'b00};
        target = base;
`ifdef BP_TRAP_VECTORED_EN
        if (is_irq && (mtvec_i[1:0] == 2'b01)) begin
            target = base + {58'b0, code, 2'b00};
        end
`endif
    end

`ifndef BP_TRAP_VECTORED_EN
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^mtvec_i[1:0];
`endif

    always_comb begin
        state_d  = state_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        tval_d   = tval_q;
        target_d = target_q;
        unique case (state_q)
            S_IDLE: begin
                if (exc_v_i && (is_irq || is_exc)) begin
                    cause_d  = {is_irq, 59'b0, code};
                    epc_d    = {{(64 - vaddr_width_p){exc_pc_i[vaddr_width_p-1]}}, exc_pc_i};
                    tval_d   = is_irq ? '0 : exc_tval_i;
                    target_d = target;
                    state_d  = S_FLUSH;
                end
            end
            S_FLUSH:    state_d = S_W_CAUSE;
            S_W_CAUSE:  if (csr_w_ready_i) state_d = S_W_EPC;
            S_W_EPC:    if (csr_w_ready_i) state_d = S_W_TVAL;
            S_W_TVAL:   if (csr_w_ready_i) state_d = S_REDIRECT;
            S_REDIRECT: state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q  <= S_IDLE;
            cause_q  <= '0;
            epc_q    <= '0;
            tval_q   <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            cause_q  <= cause_d;
            epc_q    <= epc_d;
            tval_q   <= tval_d;
            target_q <= target_d;
        end
    end

    always_comb begin
        exc_ready_o   = (state_q == S_IDLE);
        busy_o        = (state_q != S_IDLE);
        flush_o       = (state_q == S_FLUSH);
        csr_w_v_o     = 1'b0;
        csr_w_addr_o  = '0;
        csr_w_data_o  = '0;
        redirect_v_o  = 1'b0;
        redirect_pc_o = '0;
        unique case (state_q)
            S_W_CAUSE: begin
                csr_w_v_o    = 1'b1;
                csr_w_addr_o = 12'h342;
                csr_w_data_o = cause_q;
            end
            S_W_EPC: begin
                csr_w_v_o    = 1'b1;
                csr_w_addr_o = 12'h341;
                csr_w_data_o = epc_q;
            end
            S_W_TVAL: begin
                csr_w_v_o    = 1'b1;
                csr_w_addr_o = 12'h343;
                csr_w_data_o = tval_q;
            end
            S_REDIRECT: begin
                redirect_v_o  = 1'b1;
                redirect_pc_o = target_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bp_be_trap_sequencer.sv
// Scoreboard bench for bp_be_trap_sequencer: stimulus pushes expected flush/CSR/redirect events, a monitor pops and checks them.
module tb_bp_be_trap_sequencer;

    logic        clk_i = 1'b0;
    logic        reset_n_i;
    logic        exc_v_i;
    logic [15:0] exc_i;
    logic [38:0] exc_pc_i;
    logic [63:0] exc_tval_i;
    logic        exc_ready_o;
    logic [2:0]  irq_i;
    logic        irq_en_i;
    logic [63:0] mtvec_i;
    logic        csr_w_v_o;
    logic [11:0] csr_w_addr_o;
    logic [63:0] csr_w_data_o;
    logic        csr_w_ready_i;
    logic        flush_o;
    logic        redirect_v_o;
    logic [63:0] redirect_pc_o;
    logic        busy_o;

    bp_be_trap_sequencer #(.vaddr_width_p(39)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .exc_v_i(exc_v_i), .exc_i(exc_i), .exc_pc_i(exc_pc_i), .exc_tval_i(exc_tval_i),
        .exc_ready_o(exc_ready_o), .irq_i(irq_i), .irq_en_i(irq_en_i), .mtvec_i(mtvec_i),
        .csr_w_v_o(csr_w_v_o), .csr_w_addr_o(csr_w_addr_o), .csr_w_data_o(csr_w_data_o),
        .csr_w_ready_i(csr_w_ready_i), .flush_o(flush_o), .redirect_v_o(redirect_v_o),
        .redirect_pc_o(redirect_pc_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int          kind;   // 0 flush, 1 csr write, 2 redirect
        logic [11:0] addr;
        logic [63:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  ntot = 0;
    int  nbad = 0;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void unexpected(input string nm);
        ntot++;
        nbad++;
        $display("FAIL %s: got unexpected event expected none (cycle %0d)", nm, cyc);
    endfunction

    always @(negedge clk_i) begin
        #1;
        if (reset_n_i) begin
            if (flush_o) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 0) unexpected("flush");
                else begin
                    chk("flush_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
            end
            if (csr_w_v_o) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 1) unexpected("csr_write");
                else begin
                    chk("csr_addr", 64'(csr_w_addr_o), 64'(exp_q[0].addr));
                    chk("csr_data", csr_w_data_o, exp_q[0].data);
                    if (csr_w_ready_i) begin
                        chk("csr_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (redirect_v_o) begin
                if (exp_q.size() == 0 || exp_q[0].kind != 2) unexpected("redirect");
                else begin
                    chk("redirect_pc", redirect_pc_o, exp_q[0].data);
                    chk("redirect_cycle", 64'(cyc), 64'(exp_q[0].cyc));
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    // Called and returns at a negedge with the DUT idle.
    task automatic trap(input logic [15:0] exc, input logic [2:0] irq, input logic en,
                        input logic [38:0] pc, input logic [63:0] tval, input logic [63:0] mtvec,
                        input int stall, input bit take,
                        input logic [63:0] e_cause, input logic [63:0] e_epc,
                        input logic [63:0] e_tval, input logic [63:0] e_target);
        int a;
        chk("ready_idle", 64'(exc_ready_o), 64'd1);
        exc_v_i = 1'b1; exc_i = exc; irq_i = irq; irq_en_i = en;
        exc_pc_i = pc; exc_tval_i = tval; mtvec_i = mtvec;
        @(posedge clk_i); #1;
        a = cyc;
        exc_v_i = 1'b0; exc_i = 16'hFFFF; irq_i = 3'b111; irq_en_i = 1'b1;
        exc_pc_i = '1; exc_tval_i = '1; mtvec_i = 64'hFFFF_0000_0000_0001;
        if (take) begin
            exp_q.push_back('{kind: 0, addr: 12'h0,   data: 64'h0,    cyc: a});
            exp_q.push_back('{kind: 1, addr: 12'h342, data: e_cause,  cyc: a + 1});
            exp_q.push_back('{kind: 1, addr: 12'h341, data: e_epc,    cyc: a + 2 + stall});
            exp_q.push_back('{kind: 1, addr: 12'h343, data: e_tval,   cyc: a + 3 + stall});
            exp_q.push_back('{kind: 2, addr: 12'h0,   data: e_target, cyc: a + 4 + stall});
        end else begin
            chk("no_trap_idle", 64'(busy_o), 64'd0);
        end
        if (stall > 0) exc_v_i = 1'b1;
        while (cyc < a + 2) @(negedge clk_i);
        if (stall > 0) begin
            csr_w_ready_i = 1'b0;
            repeat (stall) begin
                chk("busy_not_ready", 64'(exc_ready_o), 64'd0);
                @(negedge clk_i);
            end
            csr_w_ready_i = 1'b1;
            exc_v_i = 1'b0;
        end
        while (cyc < a + 5 + stall) @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [63:0] vec_target;
    int          a;

    initial begin
`ifdef BP_TRAP_VECTORED_EN
        vec_target = 64'h8000_101C;
`else
        vec_target = 64'h8000_1000;
`endif
        reset_n_i = 1'b0; exc_v_i = 1'b0; exc_i = '0; exc_pc_i = '0; exc_tval_i = '0;
        irq_i = '0; irq_en_i = 1'b0; mtvec_i = '0; csr_w_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("rst_ready", 64'(exc_ready_o), 64'd1);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_flush", 64'(flush_o), 64'd0);
        chk("rst_csr_v", 64'(csr_w_v_o), 64'd0);
        reset_n_i = 1'b1;
        @(negedge clk_i);

        // exc, irq, en, pc, tval, mtvec, stall, take, cause, epc, tval, target
        trap(16'h0004, 3'b000, 1'b0, 39'h0_8000_0010, 64'hDEAD_BEEF, 64'h8000_1000, 0, 1'b1,
             64'd2, 64'h8000_0010, 64'hDEAD_BEEF, 64'h8000_1000);
        trap(16'hA0A9, 3'b000, 1'b0, 39'h0_8000_0020, 64'h1234, 64'h8000_1000, 0, 1'b1,
             64'd0, 64'h8000_0020, 64'h1234, 64'h8000_1000);
        trap(16'h2040, 3'b000, 1'b1, 39'h40_0000_0000, 64'h55, 64'h8000_2003, 0, 1'b1,
             64'd6, 64'hFFFF_FFC0_0000_0000, 64'h55, 64'h8000_2000);
        trap(16'h0004, 3'b011, 1'b1, 39'h0_8000_0030, 64'hABC, 64'h8000_1000, 0, 1'b1,
             64'h8000_0000_0000_0003, 64'h8000_0030, 64'h0, 64'h8000_1000);
        trap(16'h0004, 3'b011, 1'b0, 39'h0_8000_0030, 64'hABC, 64'h8000_1000, 0, 1'b1,
             64'd2, 64'h8000_0030, 64'hABC, 64'h8000_1000);
        trap(16'h0000, 3'b111, 1'b1, 39'h0_8000_0034, 64'h9, 64'h8000_1000, 0, 1'b1,
             64'h8000_0000_0000_000B, 64'h8000_0034, 64'h0, 64'h8000_1000);
        trap(16'h0000, 3'b010, 1'b1, 39'h0_8000_0038, 64'h9, 64'h8000_1001, 0, 1'b1,
             64'h8000_0000_0000_0007, 64'h8000_0038, 64'h0, vec_target);
        trap(16'h0800, 3'b000, 1'b0, 39'h0_8000_0040, 64'h0, 64'h8000_1000, 3, 1'b1,
             64'd11, 64'h8000_0040, 64'h0, 64'h8000_1000);
        trap(16'h4400, 3'b000, 1'b0, 39'h0_8000_0044, 64'h1, 64'h8000_1000, 0, 1'b0,
             64'h0, 64'h0, 64'h0, 64'h0);
        trap(16'h0000, 3'b111, 1'b0, 39'h0_8000_0048, 64'h1, 64'h8000_1000, 0, 1'b0,
             64'h0, 64'h0, 64'h0, 64'h0);

        // Asynchronous reset while the mtval write is stalled.
        chk("ready_idle", 64'(exc_ready_o), 64'd1);
        exc_v_i = 1'b1; exc_i = 16'h0004; irq_i = '0; irq_en_i = 1'b0;
        exc_pc_i = 39'h0_8000_0050; exc_tval_i = 64'h77; mtvec_i = 64'h8000_1000;
        @(posedge clk_i); #1;
        a = cyc;
        exc_v_i = 1'b0;
        exp_q.push_back('{kind: 0, addr: 12'h0,   data: 64'h0,         cyc: a});
        exp_q.push_back('{kind: 1, addr: 12'h342, data: 64'd2,         cyc: a + 1});
        exp_q.push_back('{kind: 1, addr: 12'h341, data: 64'h8000_0050, cyc: a + 2});
        exp_q.push_back('{kind: 1, addr: 12'h343, data: 64'h77,        cyc: a + 3});
        while (cyc < a + 3) @(negedge clk_i);
        csr_w_ready_i = 1'b0;
        #3;
        reset_n_i = 1'b0;
        #1;
        chk("arst_ready", 64'(exc_ready_o), 64'd1);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_csr_v", 64'(csr_w_v_o), 64'd0);
        chk("arst_csr_addr", 64'(csr_w_addr_o), 64'd0);
        chk("arst_csr_data", csr_w_data_o, 64'd0);
        chk("arst_redir", {63'd0, redirect_v_o} | redirect_pc_o, 64'd0);
        chk("arst_pending", 64'(exp_q.size()), 64'd1);
        exp_q.delete();
        @(negedge clk_i);
        csr_w_ready_i = 1'b1;
        reset_n_i = 1'b1;
        @(negedge clk_i);

        trap(16'h0004, 3'b000, 1'b0, 39'h0_8000_0060, 64'hCAFE, 64'h8000_3000, 0, 1'b1,
             64'd2, 64'h8000_0060, 64'hCAFE, 64'h8000_3000);

        repeat (3) @(negedge clk_i);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
